xadc_scan_pwm: RTL and testbench

Parametrised successor to the fixed four-channel XADC-to-LED demo logic. It scans NUM_CH DRP channel addresses and captures the top DATA_W bits of each result. Each channel feeds an optional per-channel exponential smoothing filter, which drives one PWM output. It sits between the XADC Wizard DRP port and board LEDs/DAC pins, and adds a drdy timeout, per-sample strobes and glitch-free duty updates.

---
 rtl/xadc_scan_pwm_pkg.sv | 8 +
 rtl/xadc_scan_pwm_pwm_channel.sv | 21 ++
 rtl/xadc_scan_pwm.sv | 93 +++++++++
 tb/tb_xadc_scan_pwm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_scan_pwm_pkg.sv
// xadc_scan_pwm_pkg: shared FSM states, default scan addresses and width helper
package xadc_scan_pwm_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILT} state_t;
  localparam logic [27:0] CH_ADDR_DEF = {7'h16, 7'h1F, 7'h17, 7'h1E};
  function automatic int clog2m1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/xadc_scan_pwm_pwm_channel.sv
// xadc_scan_pwm_pwm_channel: duty register reloaded on counter wrap plus registered compare
module xadc_scan_pwm_pwm_channel #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cnt,
  input  logic [DATA_W-1:0] y,
  output logic              pwm
);
  logic [DATA_W-1:0] duty;
  // reloading only at all-ones keeps every period a single clean pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (&cnt) duty <= y;
      pwm <= cnt < duty;
    end
endmodule

// File: rtl/xadc_scan_pwm.sv
// xadc_scan_pwm: DRP channel scanner with per-channel smoothing driving PWM outputs
module xadc_scan_pwm import xadc_scan_pwm_pkg::*; #(
  parameter int                   NUM_CH     = 4,
  parameter logic [NUM_CH*7-1:0]  CH_ADDR    = CH_ADDR_DEF,
  parameter int                   DATA_W     = 8,
  parameter int                   FILT_SHIFT = 0,
  parameter int                   TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           eoc,
  input  logic                           drdy,
  input  logic [15:0]                    do_in,
  output logic                           den,
  output logic [6:0]                     daddr,
  output logic [NUM_CH-1:0]              pwm,
  output logic                           sample_valid,
  output logic [clog2m1(NUM_CH)-1:0]     sample_ch,
  output logic [DATA_W-1:0]              sample_data,
  output logic                           timeout_err
);
  localparam int CW = clog2m1(NUM_CH);
  localparam int SW = DATA_W + FILT_SHIFT;
  localparam int TW = clog2m1(TIMEOUT + 1);
  state_t            state;
  logic [CW-1:0]     ch, ch_nxt, ch_d;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] x, cnt, y_nxt;
  logic [SW-1:0]     s [NUM_CH];
  logic [SW-1:0]     s_nxt;
  logic [DATA_W-1:0] y [NUM_CH];
  logic [NUM_CH-1:0] seeded;
  logic              timeout_hit, adv;
  assign timeout_hit = timer == TW'(TIMEOUT);
  assign adv    = (state == FILT) || (state == WAIT && !drdy && timeout_hit);
  assign ch_nxt = (ch == CW'(NUM_CH - 1)) ? '0 : ch + 1'b1;
  assign ch_d   = adv ? ch_nxt : ch;
  // first sample seeds the state so the output starts at the input, not at zero
  assign s_nxt  = seeded[ch] ? s[ch] + SW'(x) - (s[ch] >> FILT_SHIFT) : SW'(x) << FILT_SHIFT;
  assign y_nxt  = DATA_W'(s_nxt >> FILT_SHIFT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      timer        <= '0;
      x            <= '0;
      den          <= 1'b0;
      daddr        <= '0;
      seeded       <= '0;
      timeout_err  <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      for (int i = 0; i < NUM_CH; i++) s[i] <= '0;
    end else begin
      den          <= state == IDLE && eoc;
      sample_valid <= state == FILT;
      daddr        <= CH_ADDR[int'(ch_d)*7 +: 7];
      ch           <= ch_d;
      case (state)
        IDLE: if (eoc) state <= REQ;
        REQ: begin
          state <= WAIT;
          timer <= '0;
        end
        WAIT:
          if (drdy) begin
            x     <= DATA_W'(do_in >> (16 - DATA_W));
            state <= FILT;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else timer <= timer + 1'b1;
        FILT: begin
          s[ch]       <= s_nxt;
          seeded[ch]  <= 1'b1;
          sample_ch   <= ch;
          sample_data <= y_nxt;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= cnt + 1'b1;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign y[g] = DATA_W'(s[g] >> FILT_SHIFT);
    xadc_scan_pwm_pwm_channel #(.DATA_W(DATA_W)) u_pwm (
      .clk(clk), .rst(rst), .cnt(cnt), .y(y[g]), .pwm(pwm[g])
    );
  end
endmodule

// File: tb/tb_xadc_scan_pwm.sv
// tb_xadc_scan_pwm: scoreboard bench for a bypass and a smoothing instance driven in lockstep
module tb_xadc_scan_pwm;
  logic clk = 0, rst = 1, eoc = 0, drdy = 0;
  logic [15:0] do_in = '0;
  logic den_a, den_b, va, vb, toa, tob;
  logic [6:0] daddr_a, daddr_b;
  logic [3:0] pwm_a, pwm_b;
  logic [1:0] sca, scb;
  logic [7:0] sda, sdb;

  typedef struct { int ch; int d; } exp_t;
  exp_t qa[$], qb[$], ea, eb;
  int seqb[$];
  bit rec_b = 0;
  int checks = 0, errors = 0;
  int ch_m = 0;
  int sb[4];
  bit seed_b[4];
  int addrs[4] = '{'h1E, 'h17, 'h1F, 'h16};
  int filt_exp[4] = '{'h00, 'h20, 'h38, 'h4A};
  bit rl_en = 0;
  int run = 0, rl_lo = 0, rl_hi = 0;

  always #5 clk = ~clk;

  xadc_scan_pwm #(.FILT_SHIFT(0), .TIMEOUT(15)) dut_a (
    .clk(clk), .rst(rst), .eoc(eoc), .drdy(drdy), .do_in(do_in), .den(den_a), .daddr(daddr_a),
    .pwm(pwm_a), .sample_valid(va), .sample_ch(sca), .sample_data(sda), .timeout_err(toa));
  xadc_scan_pwm #(.FILT_SHIFT(2), .TIMEOUT(15)) dut_b (
    .clk(clk), .rst(rst), .eoc(eoc), .drdy(drdy), .do_in(do_in), .den(den_b), .daddr(daddr_b),
    .pwm(pwm_b), .sample_valid(vb), .sample_ch(scb), .sample_data(sdb), .timeout_err(tob));

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (va) begin
      if (qa.size() == 0) check("a_unexpected_valid", int'(va), 0);
      else begin
        ea = qa.pop_front();
        check("a_ch", int'(sca), ea.ch);
        check("a_data", int'(sda), ea.d);
      end
    end
    if (vb) begin
      if (rec_b && scb == 2'd0) seqb.push_back(int'(sdb));
      if (qb.size() == 0) check("b_unexpected_valid", int'(vb), 0);
      else begin
        eb = qb.pop_front();
        check("b_ch", int'(scb), eb.ch);
        check("b_data", int'(sdb), eb.d);
      end
    end
  end

  // high-pulse widths of pwm_a[0] must always be one of the two programmed duties
  always @(negedge clk)
    if (rl_en) begin
      if (pwm_a[0]) run++;
      else if (run != 0) begin
        checks++;
        if (run != rl_lo && run != rl_hi) begin
          errors++;
          $display("FAIL pwm_run: got %0d expected %0d or %0d", run, rl_lo, rl_hi);
        end
        run = 0;
      end
    end

  function automatic void model_sample(input int x);
    qa.push_back('{ch_m, x});
    if (!seed_b[ch_m]) begin
      sb[ch_m] = x * 4;
      seed_b[ch_m] = 1;
    end else sb[ch_m] = sb[ch_m] + x - sb[ch_m] / 4;
    qb.push_back('{ch_m, sb[ch_m] / 4});
    ch_m = (ch_m + 1) % 4;
  endfunction

  function automatic void model_reset();
    ch_m = 0;
    for (int i = 0; i < 4; i++) begin
      sb[i] = 0;
      seed_b[i] = 0;
    end
  endfunction

  task automatic do_read(input int x, input int k);
    int n;
    @(negedge clk); eoc = 1;
    @(negedge clk); eoc = 0; n = 1;
    check("den_on", int'(den_a), 1);
    check("daddr_a", int'(daddr_a), addrs[ch_m]);
    check("daddr_b", int'(daddr_b), addrs[ch_m]);
    model_sample(x);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); n++;
      if (i == 0) check("den_single", int'(den_a), 0);
    end
    drdy = 1; do_in = {x[7:0], 8'($urandom)};
    @(negedge clk); drdy = 0; n++;
    while (!va && n < 30) begin
      @(negedge clk); n++;
    end
    check("latency", n, 3 + k);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1;
    #1;
    check("rst_den", int'(den_a), 0);
    check("rst_pwm", int'(pwm_a | pwm_b), 0);
    check("rst_to", int'(toa | tob), 0);
    check("rst_daddr", int'(daddr_a), 0);
    check("rst_qa", qa.size(), 0);
    check("rst_qb", qb.size(), 0);
    model_reset();
    @(negedge clk); rst = 0;
    @(negedge clk);
    check("post_rst_daddr", int'(daddr_a), 'h1E);
  endtask

  task automatic count_high(output int n);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      n += int'(pwm_a[0]);
    end
  endtask

  int cnt_h;

  initial begin
    #1;
    check("init_den", int'(den_a), 0);
    check("init_valid", int'(va | vb), 0);
    check("init_data", int'(sda), 0);
    check("init_pwm", int'(pwm_a), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("init_daddr", int'(daddr_a), 'h1E);
    for (int i = 0; i < 4; i++) do_read('hA5, 3);
    for (int i = 0; i < 8; i++) do_read(int'($urandom_range(255, 0)), int'($urandom_range(5, 1)));

    apply_reset();
    do_read('h40, 3);
    repeat (300) @(negedge clk);
    count_high(cnt_h);
    check("pwm_duty40", cnt_h, 64);
    wait (!pwm_a[0]);
    run = 0; rl_lo = 64; rl_hi = 192; rl_en = 1;
    for (int i = 0; i < 3; i++) do_read(int'($urandom_range(255, 0)), 2);
    repeat (100) @(negedge clk);
    do_read('hC0, 3);
    repeat (600) @(negedge clk);
    count_high(cnt_h);
    rl_en = 0;
    check("pwm_dutyC0", cnt_h, 192);

    apply_reset();
    do_read('h00, 3);
    repeat (300) @(negedge clk);
    count_high(cnt_h);
    check("pwm_duty00", cnt_h, 0);
    for (int i = 0; i < 3; i++) do_read(int'($urandom_range(255, 0)), 1);
    do_read('hFF, 3);
    repeat (300) @(negedge clk);
    count_high(cnt_h);
    check("pwm_dutyFF", cnt_h, 255);

    apply_reset();
    rec_b = 1;
    for (int i = 0; i < 16; i++) do_read(i < 4 ? 'h00 : 'h80, int'($urandom_range(4, 1)));
    repeat (3) @(negedge clk);
    rec_b = 0;
    check("filt_count", seqb.size(), 4);
    for (int i = 0; i < 4 && i < seqb.size(); i++) check("filt_seq", seqb[i], filt_exp[i]);

    @(negedge clk); eoc = 1;
    @(negedge clk); eoc = 0;
    check("to_den", int'(den_a), 1);
    check("to_daddr", int'(daddr_a), addrs[ch_m]);
    repeat (8) @(negedge clk);
    check("to_early", int'(toa), 0);
    for (int i = 0; i < 40 && !toa; i++) @(negedge clk);
    check("timeout_a", int'(toa), 1);
    check("timeout_b", int'(tob), 1);
    ch_m = (ch_m + 1) % 4;
    @(negedge clk); drdy = 1; do_in = 16'hEEEE;
    @(negedge clk); drdy = 0;
    repeat (10) @(negedge clk);
    do_read(int'($urandom_range(255, 0)), 3);
    check("to_sticky", int'(toa), 1);

    @(negedge clk); eoc = 1;
    @(negedge clk); eoc = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("mid_den", int'(den_a), 0);
    check("mid_pwm", int'(pwm_a | pwm_b), 0);
    check("mid_to", int'(toa | tob), 0);
    check("mid_daddr", int'(daddr_a), 0);
    model_reset();
    @(negedge clk); drdy = 1; do_in = 16'h1234;
    @(negedge clk); drdy = 0; rst = 0;
    @(negedge clk);
    check("mid_daddr_rel", int'(daddr_a), 'h1E);
    repeat (5) @(negedge clk);
    do_read('h5A, 2);
    for (int i = 0; i < 6; i++) do_read(int'($urandom_range(255, 0)), int'($urandom_range(5, 1)));
    repeat (5) @(negedge clk);
    check("end_qa", qa.size(), 0);
    check("end_qb", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
